wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order ALU/PC+4 writeback path and the multi-cycle load-return path from data memory. Load returns have strict priority and cannot be stalled. ALU-side results are buffered in a small in-order FIFO, with back-pressure to the pipeline. A lookup port exposes pending (not yet written) destinations, with the youngest value, for hazard detection and forwarding.

## Interface
- DWIDTH, 32, data width of written values
- RWIDTH, 5, register index width
- DEPTH, 2, ALU-side FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid_i  in  1  ALU/PC+4 writeback request
- alu_rd_i  in  RWIDTH  destination register
- alu_data_i  in  DWIDTH  value (already selected by the writeback mux)
- alu_ready_o  out  1  request accepted this cycle when high with alu_valid_i
- mem_valid_i  in  1  load data return; always accepted
- mem_rd_i  in  RWIDTH  load destination register
- mem_data_i  in  DWIDTH  load value
- rf_we_o  out  1  registered write enable to register file
- rf_rd_o  out  RWIDTH  registered write index
- rf_data_o  out  DWIDTH  registered write data
- query_rd_i  in  RWIDTH  register to check for pending writes
- query_hit_o  out  1  query_rd_i pending in FIFO or output register
- query_data_o  out  DWIDTH  youngest pending value for query_rd_i; 0 when no hit
- pending_o  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO occupancy states: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- Transitions: push only, +1; pop only, −1; push and pop together, unchanged.
- alu_ready_o = !reset && (count < DEPTH). It is combinational from registered count. It stays low when FULL, even if a pop occurs in the same cycle.
- Accepted ALU request with rd==0: consumed and discarded. It is never enqueued and never written.
- Mem return with rd==0: discarded. It does not block the FIFO pop that cycle.
- Per-cycle output selection, in priority order:
  1. mem_valid_i with rd≠0 → output register loads mem request.
  2. FIFO non-empty → pop head into output register.
  3. FIFO empty and accepted ALU request with rd≠0 → bypass directly into output register; not enqueued.
  4. Otherwise rf_we_o=0 next cycle. rf_rd_o and rf_data_o hold their previous values.
- Accepted ALU request (rd≠0) that is not bypassed is enqueued at the tail in the same cycle.
- Ordering: a concurrent mem return is always older than every FIFO entry, so it is written first. FIFO order is strict FIFO.
- Continuous mem_valid_i starves the FIFO. This is permitted; back-pressure appears via alu_ready_o.
- Query: compares query_rd_i against valid FIFO entries and the output register (when rf_we_o=1), rd≠0 only.
  - Priority is youngest first: FIFO tail, then toward head, then output register.
  - Combinational. Does not include same-cycle inputs.

## Timing
- Reset (synchronous): rf_we_o=0, rf_rd_o=0, rf_data_o=0, count=0, pending_o=0, all FIFO valid bits cleared, alu_ready_o=0 while reset is high.
  - The first cycle after reset deasserts has alu_ready_o=1.
- Reset asserted mid-operation discards all queued and in-flight writes. No rf_we_o pulse occurs on the following cycle.
- Latency from input to rf_we_o:
  - mem request: 1 cycle.
  - ALU bypass: 1 cycle.
  - Queued ALU entry: 1 cycle after it reaches the head and no mem return is present.
- At most one rf write per cycle; rf_we_o is a single-cycle pulse per write.
- pending_o reflects count after the previous edge.

## Test plan
- Reset, then alu_valid_i=1, rd=5, data=0xDEADBEEF, no mem.
  - Next cycle: rf_we_o=1, rf_rd_o=5, rf_data_o=0xDEADBEEF.
  - pending_o=0 throughout.
- Same cycle: mem_valid_i rd=3 data=0xCAFEBABE, and ALU rd=7 data=0x11.
  - Cycle+1: write rd3=0xCAFEBABE.
  - Cycle+2: write rd7=0x11.
  - pending_o=1 at cycle+1.
- mem_valid_i held high 4 cycles (rd=1..4) while ALU pushes rd=8, 9, 10.
  - alu_ready_o drops after 2 accepts, with pending_o=2.
  - Writes in order: 1, 2, 3, 4, 8, 9; then rd10 after re-accept.
- FIFO holds rd=6 (0xA), then rd=6 (0xB); query_rd_i=6.
  - query_hit_o=1, query_data_o=0xB.
  - query_rd_i=0 gives hit=0, data=0.
- ALU rd=0 data=0xFF and mem rd=0.
  - No rf_we_o pulse, pending_o unchanged, alu_ready_o remains 1.
- With 2 entries queued and 1 in the output register, assert reset for one cycle.
  - The following cycle: rf_we_o=0, pending_o=0, alu_ready_o=1, query_hit_o=0 for all rd.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: load returns first, then queued ALU results, then ALU bypass.
// Latency: one cycle from an accepted request (or the FIFO head) to the registered rf write.
// Backpressure: alu_ready_o drops while the ALU FIFO is full; load returns are never stalled.
module wb_port_arbiter #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid_i,
  input  logic [RWIDTH-1:0]          alu_rd_i,
  input  logic [DWIDTH-1:0]          alu_data_i,
  output logic                       alu_ready_o,
  input  logic                       mem_valid_i,
  input  logic [RWIDTH-1:0]          mem_rd_i,
  input  logic [DWIDTH-1:0]          mem_data_i,
  output logic                       rf_we_o,
  output logic [RWIDTH-1:0]          rf_rd_o,
  output logic [DWIDTH-1:0]          rf_data_o,
  input  logic [RWIDTH-1:0]          query_rd_i,
  output logic                       query_hit_o,
  output logic [DWIDTH-1:0]          query_data_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // FIFO storage, kept as a circular buffer with explicit per-slot valid bits
  logic [RWIDTH-1:0] r_fifo_rd   [DEPTH];
  logic [DWIDTH-1:0] r_fifo_data [DEPTH];
  logic              r_fifo_vld  [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  // Output (register-file write) stage
  logic              r_rf_we;
  logic [RWIDTH-1:0] r_rf_rd;
  logic [DWIDTH-1:0] r_rf_data;

  logic              w_alu_acc;
  logic              w_alu_live;
  logic              w_mem_live;
  logic              w_empty;
  logic              w_pop;
  logic              w_bypass;
  logic              w_push;
  logic              w_query_hit;
  logic [DWIDTH-1:0] w_query_data;
  logic [AW-1:0]     w_qidx;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a full FIFO
  assign alu_ready_o = !reset && (r_count < CNT_FULL);

  // Requests to x0 are swallowed: an accepted ALU x0 write and a mem x0 return do nothing
  assign w_alu_acc  = alu_valid_i && alu_ready_o;
  assign w_alu_live = w_alu_acc && (alu_rd_i != '0);
  assign w_mem_live = mem_valid_i && (mem_rd_i != '0);
  assign w_empty    = (r_count == '0);

  // Load return wins the port; FIFO head next; bypass only when nothing older is waiting
  assign w_pop    = !w_mem_live && !w_empty;
  assign w_bypass = !w_mem_live && w_empty && w_alu_live;
  assign w_push   = w_alu_live && !w_bypass;

  // FIFO pointers, occupancy and slot contents
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_vld[i]  <= 1'b0;
        r_fifo_rd[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_fifo_vld[r_head] <= 1'b0;
        r_head             <= r_head + PTR_ONE;
      end
      if (w_push) begin
        r_fifo_vld[r_tail]  <= 1'b1;
        r_fifo_rd[r_tail]   <= alu_rd_i;
        r_fifo_data[r_tail] <= alu_data_i;
        r_tail              <= r_tail + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Output register: one write per cycle, index/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_we   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
    end else if (w_mem_live) begin
      r_rf_we   <= 1'b1;
      r_rf_rd   <= mem_rd_i;
      r_rf_data <= mem_data_i;
    end else if (w_pop) begin
      r_rf_we   <= 1'b1;
      r_rf_rd   <= r_fifo_rd[r_head];
      r_rf_data <= r_fifo_data[r_head];
    end else if (w_bypass) begin
      r_rf_we   <= 1'b1;
      r_rf_rd   <= alu_rd_i;
      r_rf_data <= alu_data_i;
    end else begin
      r_rf_we   <= 1'b0;
    end
  end

  // Pending-write lookup: scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    w_query_hit  = 1'b0;
    w_query_data = '0;
    w_qidx       = '0;
    if (query_rd_i != '0) begin
      if (r_rf_we && (r_rf_rd == query_rd_i)) begin
        w_query_hit  = 1'b1;
        w_query_data = r_rf_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        w_qidx = r_head + AW'(k);
        if (r_fifo_vld[w_qidx] && (r_fifo_rd[w_qidx] == query_rd_i)) begin
          w_query_hit  = 1'b1;
          w_query_data = r_fifo_data[w_qidx];
        end
      end
    end
  end

  assign query_hit_o  = w_query_hit;
  assign query_data_o = w_query_data;
  assign rf_we_o      = r_rf_we;
  assign rf_rd_o      = r_rf_rd;
  assign rf_data_o    = r_rf_data;
  assign pending_o    = r_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic against a queue model.
// Inputs are driven just after the falling edge and outputs are compared 1 time unit later.
// The model keeps the ALU backlog as a queue plus one output-register record.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int DP = 2;
  localparam int CW = $clog2(DP + 1);

  logic          clk;
  logic          reset;
  logic          alu_valid_i;
  logic [RW-1:0] alu_rd_i;
  logic [DW-1:0] alu_data_i;
  logic          alu_ready_o;
  logic          mem_valid_i;
  logic [RW-1:0] mem_rd_i;
  logic [DW-1:0] mem_data_i;
  logic          rf_we_o;
  logic [RW-1:0] rf_rd_o;
  logic [DW-1:0] rf_data_o;
  logic [RW-1:0] query_rd_i;
  logic          query_hit_o;
  logic [DW-1:0] query_data_o;
  logic [CW-1:0] pending_o;

  int n_err;
  int n_chk;

  // Reference model state
  logic [RW-1:0] m_q_rd[$];
  logic [DW-1:0] m_q_dat[$];
  logic          m_we;
  logic [RW-1:0] m_rd;
  logic [DW-1:0] m_dat;

  wb_port_arbiter #(.DWIDTH(DW), .RWIDTH(RW), .DEPTH(DP)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid_i  (alu_valid_i),
    .alu_rd_i     (alu_rd_i),
    .alu_data_i   (alu_data_i),
    .alu_ready_o  (alu_ready_o),
    .mem_valid_i  (mem_valid_i),
    .mem_rd_i     (mem_rd_i),
    .mem_data_i   (mem_data_i),
    .rf_we_o      (rf_we_o),
    .rf_rd_o      (rf_rd_o),
    .rf_data_o    (rf_data_o),
    .query_rd_i   (query_rd_i),
    .query_hit_o  (query_hit_o),
    .query_data_o (query_data_o),
    .pending_o    (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Youngest pending value for a register: queue tail first, then the output register
  task automatic model_query(input logic [RW-1:0] rd, output logic hit, output logic [DW-1:0] dat);
    hit = 1'b0;
    dat = '0;
    if (rd != '0) begin
      for (int i = m_q_rd.size() - 1; i >= 0; i--) begin
        if (!hit && m_q_rd[i] == rd) begin
          hit = 1'b1;
          dat = m_q_dat[i];
        end
      end
      if (!hit && m_we && m_rd == rd) begin
        hit = 1'b1;
        dat = m_dat;
      end
    end
  endtask

  task automatic model_clear();
    m_q_rd.delete();
    m_q_dat.delete();
    m_we  = 1'b0;
    m_rd  = '0;
    m_dat = '0;
  endtask

  // One clock: drive inputs, compare against model, advance model at the rising edge
  task automatic step(input logic rst, input logic av, input int ard, input logic [DW-1:0] adat,
                      input logic mv, input int mrd, input logic [DW-1:0] mdat, input int qrd);
    logic          exp_rdy;
    logic          exp_hit;
    logic [DW-1:0] exp_qd;
    logic          acc;
    reset       = rst;
    alu_valid_i = av;
    alu_rd_i    = RW'(ard);
    alu_data_i  = adat;
    mem_valid_i = mv;
    mem_rd_i    = RW'(mrd);
    mem_data_i  = mdat;
    query_rd_i  = RW'(qrd);
    #1;
    exp_rdy = !rst && (m_q_rd.size() < DP);
    model_query(RW'(qrd), exp_hit, exp_qd);
    chk("alu_ready", 64'(alu_ready_o), 64'(exp_rdy));
    chk("pending", 64'(pending_o), 64'(m_q_rd.size()));
    chk("rf_we", 64'(rf_we_o), 64'(m_we));
    chk("rf_rd", 64'(rf_rd_o), 64'(m_rd));
    chk("rf_data", 64'(rf_data_o), 64'(m_dat));
    chk("query_hit", 64'(query_hit_o), 64'(exp_hit));
    chk("query_data", 64'(query_data_o), 64'(exp_qd));
    @(posedge clk);
    acc = av && exp_rdy;
    if (rst) begin
      model_clear();
    end else if (mv && mrd != 0) begin
      m_we  = 1'b1;
      m_rd  = RW'(mrd);
      m_dat = mdat;
      if (acc && ard != 0) begin
        m_q_rd.push_back(RW'(ard));
        m_q_dat.push_back(adat);
      end
    end else if (m_q_rd.size() > 0) begin
      m_we  = 1'b1;
      m_rd  = m_q_rd.pop_front();
      m_dat = m_q_dat.pop_front();
      if (acc && ard != 0) begin
        m_q_rd.push_back(RW'(ard));
        m_q_dat.push_back(adat);
      end
    end else if (acc && ard != 0) begin
      m_we  = 1'b1;
      m_rd  = RW'(ard);
      m_dat = adat;
    end else begin
      m_we = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 0);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b1;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    mem_valid_i = 1'b0; mem_rd_i = '0; mem_data_i = '0;
    query_rd_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state while reset is still high
    chk("rst_we", 64'(rf_we_o), 64'd0);
    chk("rst_rd", 64'(rf_rd_o), 64'd0);
    chk("rst_data", 64'(rf_data_o), 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_ready", 64'(alu_ready_o), 64'd0);
    reset = 1'b0;
    #1;
    chk("first_ready", 64'(alu_ready_o), 64'd1);

    // ALU bypass, one-cycle latency
    step(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0, 0);
    chk("byp_we", 64'(rf_we_o), 64'd1);
    chk("byp_rd", 64'(rf_rd_o), 64'd5);
    chk("byp_data", 64'(rf_data_o), 64'hDEADBEEF);
    chk("byp_pending", 64'(pending_o), 64'd0);
    idle(1);

    // Concurrent mem return goes first, ALU queued behind it
    step(1'b0, 1'b1, 7, 32'h11, 1'b1, 3, 32'hCAFEBABE, 0);
    chk("mem_first_rd", 64'(rf_rd_o), 64'd3);
    chk("mem_first_data", 64'(rf_data_o), 64'hCAFEBABE);
    chk("mem_first_pend", 64'(pending_o), 64'd1);
    idle(1);
    chk("alu_second_rd", 64'(rf_rd_o), 64'd7);
    chk("alu_second_data", 64'(rf_data_o), 64'h11);
    idle(1);

    // Mem starvation fills the FIFO and throttles the ALU side
    step(1'b0, 1'b1, 8, 32'h8, 1'b1, 1, 32'h1, 0);
    step(1'b0, 1'b1, 9, 32'h9, 1'b1, 2, 32'h2, 0);
    chk("starve_pending", 64'(pending_o), 64'd2);
    chk("starve_ready", 64'(alu_ready_o), 64'd0);
    step(1'b0, 1'b1, 10, 32'hA, 1'b1, 3, 32'h3, 0);
    step(1'b0, 1'b1, 10, 32'hA, 1'b1, 4, 32'h4, 0);
    chk("starve_rd4", 64'(rf_rd_o), 64'd4);
    step(1'b0, 1'b1, 10, 32'hA, 1'b0, 0, '0, 0);
    chk("drain_rd8", 64'(rf_rd_o), 64'd8);
    step(1'b0, 1'b1, 10, 32'hA, 1'b0, 0, '0, 0);
    chk("drain_rd9", 64'(rf_rd_o), 64'd9);
    idle(1);
    chk("drain_rd10", 64'(rf_rd_o), 64'd10);
    idle(2);

    // Two pending writes to the same register: youngest value wins
    step(1'b0, 1'b1, 6, 32'hA, 1'b1, 1, 32'h1, 0);
    step(1'b0, 1'b1, 6, 32'hB, 1'b1, 2, 32'h2, 6);
    query_rd_i = 5'd6;
    #1;
    chk("q6_hit", 64'(query_hit_o), 64'd1);
    chk("q6_data", 64'(query_data_o), 64'hB);
    query_rd_i = 5'd0;
    #1;
    chk("q0_hit", 64'(query_hit_o), 64'd0);
    chk("q0_data", 64'(query_data_o), 64'd0);
    idle(4);

    // x0 requests are dropped on both paths
    step(1'b0, 1'b1, 0, 32'hFF, 1'b1, 0, 32'h77, 0);
    chk("x0_we", 64'(rf_we_o), 64'd0);
    chk("x0_pending", 64'(pending_o), 64'd0);
    chk("x0_ready", 64'(alu_ready_o), 64'd1);

    // Reset with two queued entries and one in the output register
    step(1'b0, 1'b1, 11, 32'hB1, 1'b1, 1, 32'h1, 0);
    step(1'b0, 1'b1, 12, 32'hB2, 1'b1, 2, 32'h2, 0);
    chk("pre_rst_pending", 64'(pending_o), 64'd2);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_we", 64'(rf_we_o), 64'd0);
    chk("post_rst_pending", 64'(pending_o), 64'd0);
    chk("post_rst_ready", 64'(alu_ready_o), 64'd1);
    for (int r = 0; r < 32; r++) begin
      query_rd_i = RW'(r);
      #1;
      chk("post_rst_qhit", 64'(query_hit_o), 64'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), $urandom_range(0, 7), $urandom,
           ($urandom_range(0, 9) < 3), $urandom_range(0, 7), $urandom, $urandom_range(0, 7));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
